// File: rtl/lightpipe_tx_sched.sv
// Double-buffered 8-channel frame scheduler: the host fills a shadow frame and
// each rising edge of the asynchronous word clock swaps it into the active frame.
module lightpipe_tx_sched #(
    parameter bit MUTE_ON_UNDERRUN = 1'b0,
    parameter int SYNC_STAGES      = 2
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         wclk,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [2:0]   s_ch,
    input  logic [23:0]  s_data,
    input  logic [3:0]   user_in,
    input  logic         underrun_clr,
    output logic [191:0] frame_o,
    output logic [3:0]   user_o,
    output logic         frame_strobe_o,
    output logic [7:0]   underrun_o,
    output logic [15:0]  frame_cnt_o,
    output logic         dbg_state_o
);

    typedef enum logic {
        FILL = 1'b0,
        SWAP = 1'b1
    } state_t;

    // Host write handshake: a sample moves when s_valid and s_ready are both
    // high at a rising mclk edge; s_ready is high exactly while in FILL.

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_sync_q;
    logic                   r_vld_q;
    logic                   r_swap_req;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // r_vld tracks which synchronizer stages hold real samples, so a wclk that
    // is already high when reset releases is not mistaken for a rising edge.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_sync     <= '0;
            r_vld      <= '0;
            r_sync_q   <= 1'b0;
            r_vld_q    <= 1'b0;
            r_swap_req <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], wclk};
            r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sync_q   <= w_sync_out;
            r_vld_q    <= r_vld[SYNC_STAGES-1];
            r_swap_req <= w_sync_out & ~r_sync_q & r_vld_q;
        end
    end

    state_t        r_state;
    logic          r_ready;
    logic [23:0]   r_shadow [8];
    logic [7:0]    r_written;
    logic          r_primed;
    logic [191:0]  r_frame;
    logic [3:0]    r_user;
    logic          r_strobe;
    logic [7:0]    r_underrun;
    logic [15:0]   r_cnt;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state    <= FILL;
            r_ready    <= 1'b0;
            for (int n = 0; n < 8; n++) r_shadow[n] <= 24'h000000;
            r_written  <= 8'h00;
            r_primed   <= 1'b0;
            r_frame    <= '0;
            r_user     <= 4'h0;
            r_strobe   <= 1'b0;
            r_underrun <= 8'h00;
            r_cnt      <= 16'h0000;
        end else begin
            r_strobe <= 1'b0;
            // A new underrun outranks a simultaneous clear on the same channel.
            if (r_state == SWAP && r_primed)
                r_underrun <= (underrun_clr ? 8'h00 : r_underrun) | ~r_written;
            else if (underrun_clr)
                r_underrun <= 8'h00;

            case (r_state)
                FILL: begin
                    if (s_valid && r_ready) begin
                        r_shadow[s_ch]  <= s_data;
                        r_written[s_ch] <= 1'b1;
                    end
                    if (r_swap_req) begin
                        r_state <= SWAP;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SWAP: begin
                    for (int n = 0; n < 8; n++) begin
                        if (r_written[n])
                            r_frame[24*n +: 24] <= r_shadow[n];
                        else if (MUTE_ON_UNDERRUN)
                            r_frame[24*n +: 24] <= 24'h000000;
                    end
                    r_user    <= user_in;
                    r_written <= 8'h00;
                    r_cnt     <= r_cnt + 16'd1;
                    r_strobe  <= 1'b1;
                    r_primed  <= 1'b1;
                    r_state   <= FILL;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state <= FILL;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready        = r_ready;
    assign frame_o        = r_frame;
    assign user_o         = r_user;
    assign frame_strobe_o = r_strobe;
    assign underrun_o     = r_underrun;
    assign frame_cnt_o    = r_cnt;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_lightpipe_tx_sched.sv
// Directed bench for lightpipe_tx_sched: one instance repeats on underrun,
// the other mutes, both driven by the same stimulus.
`timescale 1ns/1ps
module tb_lightpipe_tx_sched;

    logic         mclk = 1'b0;
    logic         rst;
    logic         wclk;
    logic         s_valid;
    logic [2:0]   s_ch;
    logic [23:0]  s_data;
    logic [3:0]   user_in;
    logic         underrun_clr;

    logic         s_ready0, s_ready1;
    logic [191:0] frame0, frame1;
    logic [3:0]   user0, user1;
    logic         strobe0, strobe1;
    logic [7:0]   under0, under1;
    logic [15:0]  cnt0, cnt1;
    logic         dbg0, dbg1;

    int           n_chk = 0;
    int           n_err = 0;
    logic [15:0]  exp_cnt;
    logic [23:0]  e0 [8];
    logic [23:0]  e1 [8];

    always #5 mclk = ~mclk;

    lightpipe_tx_sched #(.MUTE_ON_UNDERRUN(1'b0), .SYNC_STAGES(2)) dut0 (
        .mclk(mclk), .rst(rst), .wclk(wclk), .s_valid(s_valid), .s_ready(s_ready0),
        .s_ch(s_ch), .s_data(s_data), .user_in(user_in), .underrun_clr(underrun_clr),
        .frame_o(frame0), .user_o(user0), .frame_strobe_o(strobe0),
        .underrun_o(under0), .frame_cnt_o(cnt0), .dbg_state_o(dbg0)
    );

    lightpipe_tx_sched #(.MUTE_ON_UNDERRUN(1'b1), .SYNC_STAGES(2)) dut1 (
        .mclk(mclk), .rst(rst), .wclk(wclk), .s_valid(s_valid), .s_ready(s_ready1),
        .s_ch(s_ch), .s_data(s_data), .user_in(user_in), .underrun_clr(underrun_clr),
        .frame_o(frame1), .user_o(user1), .frame_strobe_o(strobe1),
        .underrun_o(under1), .frame_cnt_o(cnt1), .dbg_state_o(dbg1)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] pack(input logic [23:0] a [8]);
        logic [191:0] r;
        r = '0;
        for (int n = 0; n < 8; n++) r[24*n +: 24] = a[n];
        return r;
    endfunction

    task automatic wr(input logic [2:0] ch, input logic [23:0] data);
        s_valid = 1'b1;
        s_ch    = ch;
        s_data  = data;
        @(negedge mclk);
        s_valid = 1'b0;
    endtask

    // mode 0: plain swap, 1: write ch2 while the request is up,
    // 2: underrun_clr during SWAP, 3: reset during SWAP
    task automatic rise_wclk(input int mode);
        wclk = 1'b1;
        repeat (3) @(negedge mclk);
        chk("ready_before_swap", s_ready0, 1);
        if (mode == 1) begin
            s_valid = 1'b1;
            s_ch    = 3'd2;
            s_data  = 24'h000123;
        end
        @(negedge mclk);
        s_valid = 1'b0;
        chk("ready_in_swap", s_ready0, 0);
        chk("cnt_held_in_swap", cnt0, exp_cnt);
        chk("strobe_low_in_swap", strobe0, 0);
        chk("state_swap", dbg0, 1);
        if (mode == 3) begin
            rst = 1'b0;
            #1;
            chk("rst_frame0", frame0, 0);
            chk("rst_frame1", frame1, 0);
            chk("rst_cnt", cnt0, 0);
            chk("rst_ready", s_ready0, 0);
            chk("rst_user", user0, 0);
            chk("rst_strobe", strobe0, 0);
            chk("rst_state", dbg0, 0);
            wclk = 1'b0;
        end else begin
            if (mode == 2) underrun_clr = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
            @(negedge mclk);
            underrun_clr = 1'b0;
            chk("strobe_hi0", strobe0, 1);
            chk("strobe_hi1", strobe1, 1);
            chk("ready_after_swap", s_ready0, 1);
            chk("cnt0", cnt0, exp_cnt);
            chk("cnt1", cnt1, exp_cnt);
            chk("state_fill", dbg0, 0);
            @(negedge mclk);
            chk("strobe_lo", strobe0, 0);
            wclk = 1'b0;
            repeat (3) @(negedge mclk);
        end
    endtask

    initial begin
        rst = 1'b0; wclk = 1'b0; s_valid = 1'b0; s_ch = 3'd0; s_data = 24'h0;
        user_in = 4'h0; underrun_clr = 1'b0; exp_cnt = 16'h0000;

        // Reset state, with wclk high across release
        repeat (3) @(negedge mclk);
        wclk = 1'b1;
        chk("reset_frame", frame0, 0);
        chk("reset_user", user0, 0);
        chk("reset_under", under0, 0);
        chk("reset_cnt", cnt0, 0);
        chk("reset_strobe", strobe0, 0);
        chk("reset_ready", s_ready0, 0);
        @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        chk("ready_first_edge", s_ready0, 1);
        repeat (6) @(negedge mclk);
        chk("no_swap_high_at_release", cnt0, 0);
        wclk = 1'b0;
        repeat (3) @(negedge mclk);

        // Full first frame
        e0 = '{24'hFFFFFF, 24'h000000, 24'hFFFFFE, 24'h000001,
               24'hFFFFFD, 24'h000002, 24'hFFFFFC, 24'h000003};
        e1 = e0;
        for (int n = 0; n < 8; n++) wr(3'(n), e0[n]);
        user_in = 4'h3;
        rise_wclk(0);
        chk("f1_frame0", frame0, pack(e0));
        chk("f1_frame1", frame1, pack(e1));
        chk("f1_user", user0, 4'h3);
        chk("f1_under0", under0, 8'h00);
        chk("f1_under1", under1, 8'h00);

        // ch7 left unwritten: repeat vs mute
        for (int n = 0; n < 7; n++) begin
            e0[n] = 24'h100000 + 24'(n);
            e1[n] = e0[n];
            wr(3'(n), e0[n]);
        end
        e1[7] = 24'h000000;
        user_in = 4'hA;
        rise_wclk(0);
        chk("f2_frame_repeat", frame0, pack(e0));
        chk("f2_frame_mute", frame1, pack(e1));
        chk("f2_user", user1, 4'hA);
        chk("f2_under0", under0, 8'h80);
        chk("f2_under1", under1, 8'h80);

        // Last write wins, and a write alongside the swap request is included
        for (int n = 0; n < 8; n++) begin
            e0[n] = 24'h200000 + 24'(n);
            wr(3'(n), (n == 2) ? 24'hABCDEF : e0[n]);
        end
        e0[2] = 24'h000123;
        e1 = e0;
        rise_wclk(1);
        chk("f3_frame0", frame0, pack(e0));
        chk("f3_frame1", frame1, pack(e1));
        chk("f3_under_sticky", under0, 8'h80);

        // Plain clear, then ch0 underrun, then clear racing a ch5 underrun
        underrun_clr = 1'b1;
        @(negedge mclk);
        underrun_clr = 1'b0;
        chk("clr_under", under0, 8'h00);
        for (int n = 1; n < 8; n++) begin
            e0[n] = 24'h300000 + 24'(n);
            e1[n] = e0[n];
            wr(3'(n), e0[n]);
        end
        e1[0] = 24'h000000;
        rise_wclk(0);
        chk("f4_frame_repeat", frame0, pack(e0));
        chk("f4_frame_mute", frame1, pack(e1));
        chk("f4_under", under0, 8'h01);
        for (int n = 0; n < 8; n++) begin
            if (n != 5) begin
                e0[n] = 24'h400000 + 24'(n);
                e1[n] = e0[n];
                wr(3'(n), e0[n]);
            end
        end
        e1[5] = 24'h000000;
        rise_wclk(2);
        chk("f5_frame_repeat", frame0, pack(e0));
        chk("f5_frame_mute", frame1, pack(e1));
        chk("f5_under_clr_race0", under0, 8'h20);
        chk("f5_under_clr_race1", under1, 8'h20);

        // Reset dropped mid-SWAP with new data pending
        for (int n = 0; n < 4; n++) wr(3'(n), 24'h500000 + 24'(n));
        rise_wclk(3);
        chk("rst_under", under0, 8'h00);
        repeat (2) @(negedge mclk);
        rst = 1'b1;
        exp_cnt = 16'h0000;
        repeat (4) @(negedge mclk);
        for (int n = 0; n < 8; n++) e0[n] = 24'h000000;
        e0[0] = 24'h600000;
        e1 = e0;
        wr(3'd0, 24'h600000);
        user_in = 4'h5;
        rise_wclk(0);
        chk("post_rst_frame0", frame0, pack(e0));
        chk("post_rst_frame1", frame1, pack(e1));
        chk("post_rst_no_underrun", under0, 8'h00);
        chk("post_rst_user", user0, 4'h5);
        rise_wclk(0);
        for (int n = 0; n < 8; n++) e1[n] = 24'h000000;
        chk("primed_frame_repeat", frame0, pack(e0));
        chk("primed_frame_mute", frame1, pack(e1));
        chk("primed_under_all", under0, 8'hFF);

        // Counter wrap: fast wclk toggling gives one swap per two mclk cycles
        for (int i = 0; i < 65533; i++) begin
            wclk = 1'b1;
            @(negedge mclk);
            wclk = 1'b0;
            @(negedge mclk);
        end
        repeat (6) @(negedge mclk);
        exp_cnt = exp_cnt + 16'd65533;
        chk("cnt_preload0", cnt0, 16'hFFFF);
        chk("cnt_preload1", cnt1, exp_cnt);
        rise_wclk(0);
        chk("cnt_wrap", cnt0, 16'h0000);
        chk("wrap_under", under1, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lightpipe_tx_sched.md
LIGHTPIPE_TX_SCHED -- requirements
Module: lightpipe_tx_sched

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- MUTE_ON_UNDERRUN, 0, 0 = repeat previous sample on an unwritten channel; 1 = send zero.
- SYNC_STAGES, 2, wclk synchronizer depth (≥2).

REQ-002 Ports (name  direction  width  meaning):
- mclk  in  1  sole clock.
- rst  in  1  asynchronous active-low reset.
- wclk  in  1  word clock level; asynchronous to mclk.
- s_valid  in  1  host sample-write valid.
- s_ready  out  1  host sample-write ready.
- s_ch  in  3  target channel 0..7.
- s_data  in  24  sample value.
- user_in  in  4  user bits for the next frame.
- underrun_clr  in  1  clears sticky underrun flags.
- frame_o  out  192  active frame to the framer; channel n on bits [24n+23:24n].
- user_o  out  4  active user bits.
- frame_strobe_o  out  1  one-cycle pulse when frame_o/user_o update.
- underrun_o  out  8  sticky per-channel underrun flags.
- frame_cnt_o  out  16  completed swaps count.

Function
REQ-003 wclk SHALL pass through SYNC_STAGES flops clocked by mclk; a 0→1 transition at the synchronizer output SHALL produce a one-cycle internal swap request.
REQ-004 FSM SHALL have states FILL and SWAP; reset state is FILL.
REQ-005 FILL→SWAP on swap request; SWAP→FILL unconditionally after one cycle; no other transitions.
REQ-006 s_ready SHALL be 1 in FILL and 0 in SWAP.
REQ-007 A write (s_valid & s_ready) SHALL store s_data into shadow[s_ch] and set written[s_ch].
REQ-008 Multiple writes to one channel within a frame: last write wins.
REQ-009 A write accepted in the same cycle the swap request is raised SHALL be included in the swap it triggers.
REQ-010 In SWAP, for each channel n: written[n]=1 → active[n] = shadow[n]; written[n]=0 → active[n] = previous active[n] (MUTE_ON_UNDERRUN=0) or 0 (MUTE_ON_UNDERRUN=1).
REQ-011 In SWAP, user_o SHALL load user_in, written SHALL clear to 0, and frame_cnt_o SHALL increment modulo 2^16 (0xFFFF→0x0000).
REQ-012 frame_o, user_o, frame_cnt_o SHALL change only at the clock edge ending SWAP; frame_strobe_o SHALL be 1 for exactly the following cycle.
REQ-013 Latency: wclk rise reaching the first sync flop at edge k → SWAP state during cycle k+SYNC_STAGES+1 → frame_o valid from edge k+SYNC_STAGES+2.
REQ-014 Underrun: at a SWAP with primed=1, underrun_o[n] SHALL set for each n with written[n]=0; flags are sticky.
REQ-015 primed SHALL be 0 after reset and SHALL set at the end of the first SWAP; the first SWAP never sets underrun flags.
REQ-016 underrun_clr SHALL clear all underrun_o bits; a simultaneous new underrun on channel n takes priority (bit n ends at 1).
REQ-017 wclk held high or low indefinitely SHALL produce no further swaps; wclk pulses shorter than one mclk period may be missed, which is permitted.

Reset
REQ-018 While rst=0: frame_o=0, user_o=0, underrun_o=0, frame_cnt_o=0, frame_strobe_o=0, s_ready=0, shadow=0, written=0, primed=0, synchronizer flops=0, state=FILL.
REQ-019 Reset asserted mid-SWAP SHALL abort the swap; outputs take reset values immediately (asynchronously).
REQ-020 After rst release, s_ready=1 from the first mclk edge; a wclk already high at release SHALL NOT generate a swap until it goes low and high again.

Verification
REQ-021 Write ch0..7 = 0xFFFFFF,0,0xFFFFFE,1,0xFFFFFD,2,0xFFFFFC,3; user_in=0x3; wclk rise -> after SYNC_STAGES+2 edges frame_o holds those values, user_o=0x3, frame_strobe_o pulses once, frame_cnt_o=1, underrun_o=0.
REQ-022 Second frame writes only ch0..6; MUTE_ON_UNDERRUN=0 -> ch7 repeats 3, underrun_o=0x80; rerun with MUTE_ON_UNDERRUN=1 -> ch7=0, underrun_o=0x80.
REQ-023 Write ch2=0x000123 in the cycle the swap request is raised -> that swap outputs ch2=0x000123; s_ready=0 for exactly the SWAP cycle.
REQ-024 Assert underrun_clr in the same cycle a SWAP flags ch5 with underrun_o=0x01 beforehand -> underrun_o=0x20.
REQ-025 Preload frame_cnt_o to 0xFFFF via 65535 swaps, one more wclk rise -> frame_cnt_o=0x0000.
REQ-026 Drop rst during SWAP with new data pending -> frame_o=0, frame_cnt_o=0, s_ready=0 immediately; after release, first swap sets no underrun flags.
